// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub
//   Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
//   handshakes on both sides. Stage 1 conditions the operands and forms
//   per-bit and per-group generate/propagate terms. Stage 2 runs the
//   block-level lookahead, resolves in-group carries and registers the
//   result together with its status flags.
//
// Parameters
//   WIDTH  operand/result width, a multiple of GROUP and at least GROUP
//   GROUP  bits per lookahead group
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   operand set present
//   in_ready   block can accept an operand set this cycle
//   op         0 = add, 1 = subtract
//   a, b       operands
//   c_in       carry-in (add) / borrow-in (subtract)
//   out_valid  result present
//   out_ready  consumer accepts the result this cycle
//   sum        result
//   c_out      raw carry out of the MSB (NOT-borrow when subtracting)
//   ovf        two's-complement signed overflow
//   zero       sum == 0
//   neg        sum[WIDTH-1]
module cla_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NG = WIDTH / GROUP;

  if (((WIDTH % GROUP) != 0) || (WIDTH < GROUP)) begin : g_bad_params
    $fatal(1, "cla_pipe_addsub: WIDTH must be a non-zero multiple of GROUP");
  end

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic s1_valid;
  logic adv2;
  logic accept;

  assign adv2     = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | adv2;
  assign accept   = in_valid & in_ready;

  // ---------------------------------------------------------------------
  // Stage 1: operand conditioning and per-group G/P
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] b_cond;
  logic             cin_cond;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] g_bit;
  logic [NG-1:0]    g_grp;
  logic [NG-1:0]    p_grp;
  logic             g_acc;
  logic             p_acc;

  assign b_cond   = op ? ~b : b;
  assign cin_cond = op ? ~c_in : c_in;
  assign p_bit    = a ^ b_cond;
  assign g_bit    = a & b_cond;

  // Group terms built LSB to MSB: G = g_j | p_j & G_lower, P = p_j & P_lower.
  always_comb begin
    g_grp = '0;
    p_grp = '0;
    g_acc = 1'b0;
    p_acc = 1'b1;
    for (int k = 0; k < NG; k++) begin
      g_acc = 1'b0;
      p_acc = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        g_acc = g_bit[k*GROUP+j] | (p_bit[k*GROUP+j] & g_acc);
        p_acc = p_bit[k*GROUP+j] & p_acc;
      end
      g_grp[k] = g_acc;
      p_grp[k] = p_acc;
    end
  end

  // The conditioned operands themselves are not kept: p and g already
  // carry everything stage 2 needs to form the sum and the carries.
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] g_r;
  logic [NG-1:0]    gg_r;
  logic [NG-1:0]    pg_r;
  logic             cin_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      p_r      <= '0;
      g_r      <= '0;
      gg_r     <= '0;
      pg_r     <= '0;
      cin_r    <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        p_r      <= p_bit;
        g_r      <= g_bit;
        gg_r     <= g_grp;
        pg_r     <= p_grp;
        cin_r    <= cin_cond;
      end else if (adv2) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: block-level lookahead, in-group carries, sum and flags
  // ---------------------------------------------------------------------
  logic [NG:0]      c_grp;
  logic [WIDTH-1:0] c_bit;
  logic [WIDTH-1:0] sum_c;
  logic             c_run;

  always_comb begin
    c_grp    = '0;
    c_bit    = '0;
    c_run    = 1'b0;
    c_grp[0] = cin_r;
    for (int k = 0; k < NG; k++) begin
      c_grp[k+1] = gg_r[k] | (pg_r[k] & c_grp[k]);
    end
    // Within a group, carries start from the group carry-in supplied by
    // the block-level unit, so no carry crosses a group boundary here.
    for (int k = 0; k < NG; k++) begin
      c_run = c_grp[k];
      for (int j = 0; j < GROUP; j++) begin
        c_bit[k*GROUP+j] = c_run;
        c_run = g_r[k*GROUP+j] | (p_r[k*GROUP+j] & c_run);
      end
    end
  end

  assign sum_c = p_r ^ c_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else begin
      if (adv2) begin
        out_valid <= 1'b1;
        sum       <= sum_c;
        c_out     <= c_grp[NG];
        ovf       <= c_bit[WIDTH-1] ^ c_grp[NG];
        zero      <= ~|sum_c;
        neg       <= sum_c[WIDTH-1];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
module tb_cla_pipe_addsub;

  localparam int W = 16;
  localparam int N = 1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out, ovf, zero, neg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .reset(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero), .neg(neg)
  );

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         neg;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Golden model: wide integer addition on the conditioned operands,
  // overflow from operand/result sign agreement.
  function automatic logic [W+3:0] model(input logic m_op, input logic [W-1:0] m_a,
                                          input logic [W-1:0] m_b, input logic m_cin);
    logic [W-1:0] bb;
    logic         ci;
    logic [W:0]   full;
    logic         v;
    bb   = m_op ? ~m_b : m_b;
    ci   = m_op ? ~m_cin : m_cin;
    full = {1'b0, m_a} + {1'b0, bb} + {{W{1'b0}}, ci};
    v    = (m_a[W-1] == bb[W-1]) && (full[W-1] != m_a[W-1]);
    return {full[W-1:0], full[W], v, (full[W-1:0] == '0), full[W-1]};
  endfunction

  function automatic logic [W+3:0] dut_res();
    return {sum, c_out, ovf, zero, neg};
  endfunction

  // One isolated operation: accept, measure latency, compare result.
  task automatic run_vec(input int idx);
    int lat;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op   = vecs[idx].op;
    a    = vecs[idx].a;
    b    = vecs[idx].b;
    c_in = vecs[idx].cin;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("vec%0d_latency", idx), lat, 2);
    check($sformatf("vec%0d_result", idx), dut_res(),
          {vecs[idx].sum, vecs[idx].cout, vecs[idx].ovf, vecs[idx].zero, vecs[idx].neg});
  endtask

  task automatic drive_rand();
    in_valid = 1'b1;
    op   = 1'($urandom_range(0, 1));
    a    = W'($urandom);
    b    = W'($urandom);
    c_in = 1'($urandom_range(0, 1));
  endtask

  task automatic run_stream(input bit rand_ready);
    logic [W+3:0] q[$];
    logic [W+3:0] exp;
    int sent = 0, recv = 0, cyc = 0, stalls = 0;
    @(posedge clk); #1;
    drive_rand();
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    while ((sent < N || q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stream_unexpected_result", 1, 0);
        end else begin
          exp = q.pop_front();
          check($sformatf("stream%0d_res%0d", rand_ready, recv), dut_res(), exp);
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(op, a, b, c_in));
        sent++;
      end else if (in_valid) begin
        stalls++;
      end
      @(posedge clk); #1;
      cyc++;
      if (sent < N && (!rand_ready || $urandom_range(0, 3) != 0)) drive_rand();
      else in_valid = 1'b0;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check($sformatf("stream%0d_timeout", rand_ready), (cyc < 20000), 1);
    check($sformatf("stream%0d_count", rand_ready), recv, N);
    if (!rand_ready) begin
      check("stream_stalls", stalls, 0);
      check("stream_throughput", (cyc <= N + 3), 1);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 16'h1234, 16'h0FFF, 1'b1, 16'h2234, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_outputs", dut_res(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Backpressure: two accepted, third refused, first result held.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; op = 1'b0; c_in = 1'b0; a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1;
    a = 16'h0002; b = 16'h0002;
    check("bp_ready_second", in_ready, 1);
    @(posedge clk); #1;
    a = 16'h0003; b = 16'h0003;
    check("bp_ready_third", in_ready, 0);
    check("bp_first_valid", out_valid, 1);
    check("bp_first_sum", sum, 16'h0002);
    repeat (3) @(posedge clk);
    #1;
    check("bp_ready_held", in_ready, 0);
    check("bp_first_held", dut_res(), model(1'b0, 16'h0001, 16'h0001, 1'b0));
    out_ready = 1'b1;
    #1;
    check("bp_ready_release", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_sum", sum, 16'h0004);
    check("bp_second_valid", out_valid, 1);
    @(posedge clk); #1;
    check("bp_third_sum", sum, 16'h0006);
    check("bp_third_valid", out_valid, 1);
    @(posedge clk); #1;
    check("bp_drained", out_valid, 0);

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 1'b1; a = 16'h0005; b = 16'h0007; c_in = 1'b0;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'h0001; op = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_full_before", {out_valid, in_ready}, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_outputs", dut_res(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready_after", in_ready, 1);
    begin
      int stale = 0;
      repeat (5) begin
        @(posedge clk); #1;
        if (out_valid) stale++;
      end
      check("rst_no_stale", stale, 0);
    end

    run_stream(1'b0);
    run_stream(1'b1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
